// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Pure declarations; no timing or flow-control behaviour of its own.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int DATA_BITS = 8;

  // Bit value that makes the total count of ones (data plus this bit) even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick marks the last clk of each serial bit, 0 latency from count.
// No flow control; clr holds the count at zero so every bit starts aligned.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a registered-output FIFO and sends them as 8N1 (optional even parity) frames.
// 3 clk from IDLE decision to start bit; en only gates new frames, a running frame always completes.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int IDXW = $clog2(DATA_BITS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IDXW-1:0]      bit_idx_q, bit_idx_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 baud_clr;
  logic                 baud_tick;

  // Counter only runs while a frame is on the wire; LOAD zeroes it for the start bit.
  assign baud_clr = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    unique case (state_q)
      IDLE: begin
        if (en && !fifo_empty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d  = fifo_dout;
        parity_d = even_parity(fifo_dout);
        state_d  = START;
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == LAST_IDX) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDXW'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // tx is computed from the next state so the registered line changes with the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  assign tx        = tx_q;
  assign fifo_rd   = (state_q == FETCH);
  assign busy      = (state_q != IDLE);
  assign byte_done = (state_q == STOP) && baud_tick;

endmodule
